// File: rtl/de1_blinker_digit_out.sv
// Purpose : Avalon-MM slave holding one BCD digit for the DE1 7-segment path, with a
//           prescaler that can auto-increment (mod 10) and/or blink the digit.
// Latency : writes land on the next clock edge; readdata is registered, 1 cycle after address.
// Backpr. : none; the slave never inserts wait states.
// Ports   : clk, reset_n (async active-low), address[1:0], chipselect, write_n,
//           writedata[31:0], readdata[31:0], out_port[3:0] (digit), out_blank (blink off-phase).
// Map     : 0 DATA[3:0], 1 CTRL{AUTO_INC,BLINK_EN}, 2 PERIOD, 3 STATUS{WRAP,phase} (write clears WRAP).
module de1_blinker_digit_out #(
  parameter int unsigned PRESCALE_W   = 26,
  parameter int unsigned RESET_PERIOD = 25_000_000,
  parameter logic [3:0]  RESET_DATA   = 4'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  out_port,
  output logic        out_blank
);

  localparam logic [PRESCALE_W-1:0] PERIOD_RST = RESET_PERIOD[PRESCALE_W-1:0];

  logic [3:0]            data_q, data_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic                  wrap_q, wrap_d;
  logic [31:0]           readdata_q, readdata_d;

  logic wr_en, wr_data, wr_ctrl, wr_period, wr_status;
  logic run, tick, inc;

  // Upper writedata bits are don't-care for every register.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata};

  assign wr_en     = chipselect & ~write_n;
  assign wr_data   = wr_en && (address == 2'd0);
  assign wr_ctrl   = wr_en && (address == 2'd1);
  assign wr_period = wr_en && (address == 2'd2);
  assign wr_status = wr_en && (address == 2'd3);

  assign run  = ctrl_q[0] | ctrl_q[1];
  // A PERIOD write reloads the counter and swallows a tick due in the same cycle.
  assign tick = run && (cnt_q == '0) && !wr_period;
  assign inc  = tick && ctrl_q[1];

  always_comb begin
    data_d     = data_q;
    ctrl_d     = ctrl_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    wrap_d     = wrap_q;
    readdata_d = '0;

    if (wr_ctrl)   ctrl_d   = writedata[1:0];
    if (wr_period) period_d = writedata[PRESCALE_W-1:0];

    // Idle holds the counter at PERIOD, so enabling starts a full period.
    if (wr_period)          cnt_d = writedata[PRESCALE_W-1:0];
    else if (!run)          cnt_d = period_q;
    else if (cnt_q == '0)   cnt_d = period_q;
    else                    cnt_d = cnt_q - PRESCALE_W'(1);

    // CPU write beats the tick increment; out-of-range digits wrap straight to 0.
    if (wr_data)  data_d = writedata[3:0];
    else if (inc) data_d = (data_q >= 4'd9) ? 4'd0 : data_q + 4'd1;

    // Set after clear so a wrap in the same cycle as a STATUS write survives.
    if (wr_status) wrap_d = 1'b0;
    if (inc && !wr_data && (data_q >= 4'd9)) wrap_d = 1'b1;

    if (tick && ctrl_q[0]) phase_d = ~phase_q;
    // Blink disabled (now or by this write): phase parks at 0.
    if (!ctrl_d[0]) phase_d = 1'b0;

    case (address)
      2'd0:    readdata_d = {28'd0, data_q};
      2'd1:    readdata_d = {30'd0, ctrl_q};
      2'd2:    readdata_d = 32'(period_q);
      default: readdata_d = {30'd0, wrap_q, phase_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_DATA;
      ctrl_q     <= 2'b00;
      period_q   <= PERIOD_RST;
      cnt_q      <= PERIOD_RST;
      phase_q    <= 1'b0;
      wrap_q     <= 1'b0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      wrap_q     <= wrap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata  = readdata_q;
  assign out_port  = data_q;
  assign out_blank = ctrl_q[0] & phase_q;

endmodule
